// File: rtl/sample_fifo.sv
// sample_fifo: single-clock FIFO that buffers audio samples between the I2S
// deserialiser and its downstream consumers.
//
// Ports:
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   flush_i         synchronous flush; discards all contents
//   clr_err_i       clears the sticky overflow/underflow flags
//   wr_en_i/wr_data_i   write request and data
//   rd_en_i         read request (pops the displayed head word in FWFT mode)
//   rd_data_o/rd_valid_o read data and its valid qualifier
//   full_o, empty_o, almost_full_o, almost_empty_o, level_o  occupancy status
//   overflow_o/underflow_o  sticky error flags (dropped write / rejected read)
//
// All DEPTH entries are usable; pointers carry one extra MSB so full and
// empty are distinguishable, and the level is their modulo difference.

module sample_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 24,
    parameter int unsigned FWFT  = 0,
    parameter int unsigned AF_TH = DEPTH - 2,
    parameter int unsigned AE_TH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       clr_err_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             rd_acc;
    logic             wr_acc;

    // Status is a pure function of the registered pointers.
    assign level          = wr_ptr - rd_ptr;
    assign level_o        = level;
    assign full_o         = (level == LW'(DEPTH));
    assign empty_o        = (level == '0);
    assign almost_full_o  = (level >= LW'(AF_TH));
    assign almost_empty_o = (level <= LW'(AE_TH));

    // A read frees a slot in the same cycle, so a full FIFO still accepts a
    // write paired with a read; the converse (write rescuing a read) is not allowed.
    assign rd_acc = rd_en_i && !empty_o;
    assign wr_acc = wr_en_i && (!full_o || rd_acc);

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + LW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + LW'(1);
        end
    end

    // Memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data_i;
    end

    // A new error in the same cycle as clr_err_i wins (later assignment).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (clr_err_i) begin
                overflow_o  <= 1'b0;
                underflow_o <= 1'b0;
            end
            if (!flush_i && wr_en_i && !wr_acc) overflow_o  <= 1'b1;
            if (!flush_i && rd_en_i && !rd_acc) underflow_o <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero while empty so the
            // output is defined after reset even though memory is not.
            assign rd_data_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];
            assign rd_valid_o = !empty_o;
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush_i) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rd_ptr[AW-1:0]];
                end
            end

            assign rd_data_o  = rd_data_q;
            assign rd_valid_o = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo: a registered-mode instance (DEPTH=8,
// WIDTH=16) and an FWFT instance (DEPTH=4, WIDTH=16) sharing clk/rst_n.

module tb_sample_fifo;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Registered-mode instance
    logic        a_flush, a_clr, a_wr_en, a_rd_en;
    logic [15:0] a_wr_data, a_rd_data;
    logic        a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [3:0]  a_level;

    sample_fifo #(.DEPTH(8), .WIDTH(16), .FWFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_i(a_flush), .clr_err_i(a_clr),
        .wr_en_i(a_wr_en), .wr_data_i(a_wr_data), .rd_en_i(a_rd_en),
        .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid), .full_o(a_full),
        .empty_o(a_empty), .almost_full_o(a_af), .almost_empty_o(a_ae),
        .level_o(a_level), .overflow_o(a_ovf), .underflow_o(a_udf)
    );

    // FWFT instance
    logic        b_flush, b_clr, b_wr_en, b_rd_en;
    logic [15:0] b_wr_data, b_rd_data;
    logic        b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0]  b_level;

    sample_fifo #(.DEPTH(4), .WIDTH(16), .FWFT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(b_flush), .clr_err_i(b_clr),
        .wr_en_i(b_wr_en), .wr_data_i(b_wr_data), .rd_en_i(b_rd_en),
        .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .full_o(b_full),
        .empty_o(b_empty), .almost_full_o(b_af), .almost_empty_o(b_ae),
        .level_o(b_level), .overflow_o(b_ovf), .underflow_o(b_udf)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [15:0] q[$];
    logic [15:0] exp_rd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_flush = 0; a_clr = 0; a_wr_en = 0; a_rd_en = 0; a_wr_data = '0;
        b_flush = 0; b_clr = 0; b_wr_en = 0; b_rd_en = 0; b_wr_data = '0;
        tick();
        tick();

        // Reset state
        chk("rst_level", a_level, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_af", a_af, 0);
        chk("rst_valid", a_rd_valid, 0);
        chk("rst_data", a_rd_data, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_udf", a_udf, 0);
        chk("b_rst_valid", b_rd_valid, 0);
        chk("b_rst_data", b_rd_data, 0);
        rst_n = 1'b1;

        // Fill 1..8
        for (int i = 1; i <= 8; i++) begin
            a_wr_en = 1; a_wr_data = 16'(i);
            tick();
            q.push_back(16'(i));
            chk("fill_level", a_level, i);
            chk("fill_af", a_af, (i >= 6) ? 1 : 0);
            chk("fill_ae", a_ae, (i <= 2) ? 1 : 0);
            chk("fill_full", a_full, (i == 8) ? 1 : 0);
        end
        chk("fill_ovf", a_ovf, 0);

        // Overflow on full
        a_wr_data = 16'h00AA;
        tick();
        a_wr_en = 0;
        chk("ovf_set", a_ovf, 1);
        chk("ovf_level", a_level, 8);

        // Drain 8 with one-cycle latency
        a_rd_en = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_rd = q.pop_front();
            chk("drain_valid", a_rd_valid, 1);
            chk("drain_data", a_rd_data, exp_rd);
            chk("drain_exp", a_rd_data, i);
        end
        a_rd_en = 0;
        tick();
        chk("drain_valid_low", a_rd_valid, 0);
        chk("drain_empty", a_empty, 1);
        chk("drain_hold", a_rd_data, 16'h0008);

        a_clr = 1;
        tick();
        a_clr = 0;
        chk("clr_ovf", a_ovf, 0);

        // Refill, then simultaneous read/write on full, then 20 pairs across wrap
        a_wr_en = 1;
        for (int i = 1; i <= 8; i++) begin
            a_wr_data = 16'h0100 + 16'(i);
            q.push_back(a_wr_data);
            tick();
        end
        chk("refill_full", a_full, 1);
        a_rd_en = 1; a_wr_data = 16'h0BEE;
        q.push_back(16'h0BEE);
        tick();
        exp_rd = q.pop_front();
        chk("full_rw_level", a_level, 8);
        chk("full_rw_data", a_rd_data, 16'h0101);
        chk("full_rw_ovf", a_ovf, 0);
        for (int k = 0; k < 20; k++) begin
            a_wr_data = 16'h0200 + 16'(k);
            q.push_back(a_wr_data);
            tick();
            exp_rd = q.pop_front();
            chk("pair_data", a_rd_data, exp_rd);
            chk("pair_level", a_level, 8);
        end
        a_wr_en = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_rd = q.pop_front();
            chk("pair_drain", a_rd_data, exp_rd);
        end
        a_rd_en = 0;
        tick();
        chk("pair_empty", a_empty, 1);
        chk("pair_ovf", a_ovf, 0);

        // Empty: read+write together -> underflow, write accepted
        a_rd_en = 1; a_wr_en = 1; a_wr_data = 16'h1234;
        tick();
        a_wr_en = 0;
        chk("udf_set", a_udf, 1);
        chk("udf_level", a_level, 1);
        chk("udf_valid", a_rd_valid, 0);
        tick();
        a_rd_en = 0;
        chk("udf_read", a_rd_data, 16'h1234);
        chk("udf_read_valid", a_rd_valid, 1);
        a_clr = 1;
        tick();
        chk("clr_udf", a_udf, 0);
        // Clear coinciding with a new error: error wins
        a_rd_en = 1;
        tick();
        chk("clr_vs_err", a_udf, 1);
        a_rd_en = 0; a_clr = 1;
        tick();
        a_clr = 0;
        chk("clr_udf2", a_udf, 0);

        // FWFT instance
        b_wr_en = 1; b_wr_data = 16'h00C3;
        tick();
        b_wr_en = 0;
        chk("fwft_data", b_rd_data, 16'h00C3);
        chk("fwft_valid", b_rd_valid, 1);
        chk("fwft_empty", b_empty, 0);
        b_rd_en = 1;
        tick();
        b_rd_en = 0;
        chk("fwft_pop_empty", b_empty, 1);
        chk("fwft_pop_valid", b_rd_valid, 0);

        // Flush with level 5 and overflow set
        a_wr_en = 1;
        for (int i = 0; i < 9; i++) begin
            a_wr_data = 16'h0300 + 16'(i);
            tick();
        end
        a_wr_en = 0;
        chk("pre_flush_ovf", a_ovf, 1);
        a_rd_en = 1;
        tick(); tick(); tick();
        a_rd_en = 0;
        chk("pre_flush_level", a_level, 5);
        chk("pre_flush_data", a_rd_data, 16'h0302);
        a_flush = 1; a_wr_en = 1; a_wr_data = 16'h0DEF;
        tick();
        a_flush = 0; a_wr_en = 0;
        chk("flush_level", a_level, 0);
        chk("flush_empty", a_empty, 1);
        chk("flush_ovf", a_ovf, 1);
        chk("flush_valid", a_rd_valid, 0);
        chk("flush_hold", a_rd_data, 16'h0302);
        tick();
        chk("flush_no_write", a_level, 0);

        // Reset mid-operation
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("rst2_level", a_level, 0);
        chk("rst2_empty", a_empty, 1);
        chk("rst2_ae", a_ae, 1);
        chk("rst2_af", a_af, 0);
        chk("rst2_full", a_full, 0);
        chk("rst2_ovf", a_ovf, 0);
        chk("rst2_udf", a_udf, 0);
        chk("rst2_data", a_rd_data, 0);
        chk("rst2_valid", a_rd_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
